// File: rtl/inc16_pkg.sv
// ----------------------------------------------------------------------------
// inc16_pkg
//   Shared width constant and word type for the 16-bit incrementer slice.
//   Contents:
//     INC16_W : datapath width (16)
//     word_t  : one datapath word, used for operands and results
// ----------------------------------------------------------------------------
package inc16_pkg;

  localparam int INC16_W = 16;

  typedef logic [INC16_W-1:0] word_t;

endpackage : inc16_pkg

// File: rtl/inc16_half_adder.sv
// ----------------------------------------------------------------------------
// inc16_half_adder
//   One-bit half adder. This is the cell of the incrementer's carry chain.
//   Ports:
//     a     in  1  first operand bit
//     b     in  1  second operand bit (the incoming carry in the chain)
//     sum   out 1  a XOR b
//     carry out 1  a AND b
// ----------------------------------------------------------------------------
module inc16_half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule : inc16_half_adder

// File: rtl/inc16_pipe.sv
// ----------------------------------------------------------------------------
// inc16_pipe
//   Registered 16-bit incrementer: out_data = in_data + 1 (mod 2^16), with
//   one cycle of latency and one result per cycle. The datapath is a carry
//   chain of 16 half adders whose carry-in is tied to 1. There is no
//   backpressure, so the consumer must take out_data whenever out_valid is
//   high.
//
//   Ports:
//     clk       in  1   system clock, rising edge
//     rst_n     in  1   asynchronous reset, active low
//     in_valid  in  1   in_data is valid this cycle
//     in_data   in  16  operand
//     bypass    in  1   (INC16_BYPASS_EN only) pass in_data through unchanged
//     out_valid out 1   out_data holds a new result
//     out_data  out 16  registered result
//     out_carry out 1   carry out of bit 15 (high only for in_data = 16'hFFFF)
//
//   Build option:
//     INC16_BYPASS_EN - adds the bypass input. This supports hold-PC style use.
//                       When bypass is high at a capture edge, in_data is stored
//                       as is and out_carry is cleared.
// ----------------------------------------------------------------------------
module inc16_pipe
  import inc16_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid,
  input  word_t in_data,
`ifdef INC16_BYPASS_EN
  input  logic  bypass,
`endif
  output logic  out_valid,
  output word_t out_data,
  output logic  out_carry
);

  // c[i] is the carry into bit i. The chain is seeded with 1, which makes
  // the adder an incrementer.
  logic [INC16_W:0] c;
  word_t            sum;
  word_t            next_data;
  logic             next_carry;

  assign c[0] = 1'b1;

  for (genvar i = 0; i < INC16_W; i++) begin : g_chain
    inc16_half_adder u_ha (
      .a     (in_data[i]),
      .b     (c[i]),
      .sum   (sum[i]),
      .carry (c[i+1])
    );
  end

  // NOTE: every output of an always_comb block is assigned a default first.
  // This keeps the block purely combinational, so no latch is inferred.
  always_comb begin
    next_data  = sum;
    next_carry = c[INC16_W];
`ifdef INC16_BYPASS_EN
    if (bypass) begin
      next_data  = in_data;
      next_carry = 1'b0;
    end
`endif
  end

  // NOTE: the state updates use non-blocking assignments, so every register
  // samples values from before the clock edge. Reset is asynchronous, so a
  // mid-stream reset clears the outputs at once and drops any pending capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Data and carry load only on a valid input. This holds the last result
      // and keeps an undriven in_data from reaching the outputs.
      if (in_valid) begin
        out_data  <= next_data;
        out_carry <= next_carry;
      end
    end
  end

endmodule : inc16_pipe

// File: tb/tb_inc16_pipe.sv
// ----------------------------------------------------------------------------
// tb_inc16_pipe
//   Self-checking bench for inc16_pipe. Each scenario is a task that drives
//   stimulus and compares the outputs with expectations computed in plain
//   arithmetic. Inputs change 1 time unit after the rising edge, and outputs
//   are sampled at the same point, well away from the edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inc16_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
`ifdef INC16_BYPASS_EN
  logic        bypass;
`endif
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_carry;

  int checks;
  int errors;

  inc16_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef INC16_BYPASS_EN
    .bypass    (bypass),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_carry (out_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the result of presenting d (and bypass flag bp).
  function automatic logic [16:0] model(input logic [15:0] d, input logic bp);
    int s;
    if (bp) return {1'b0, d};
    s = int'(d) + 1;
    return {(s >= 65536), 16'(s % 65536)};
  endfunction

  task automatic test_reset();
    logic [16:0] m;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
`ifdef INC16_BYPASS_EN
    bypass   = 1'b0;
`endif
    tick();
    tick();
    checks++;
    if ({out_valid, out_carry, out_data} !== 18'h0) begin
      errors++;
      $display("FAIL reset_initial got v=%b c=%b d=%h want v=0 c=0 d=0000",
               out_valid, out_carry, out_data);
    end
    // Release reset mid-cycle. The first edge after release captures.
    #3 rst_n = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h1233;
    tick();
    m = model(16'h1233, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== m[15:0] || out_carry !== m[16]) begin
      errors++;
      $display("FAIL reset_first_capture got v=%b c=%b d=%h want v=1 c=%b d=%h",
               out_valid, out_carry, out_data, m[16], m[15:0]);
    end
    // Assert reset mid-cycle with non-zero outputs. The clear must be
    // immediate, with no clock edge.
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_carry, out_data} !== 18'h0) begin
      errors++;
      $display("FAIL reset_async got v=%b c=%b d=%h want v=0 c=0 d=0000",
               out_valid, out_carry, out_data);
    end
    // Reset held across an edge with a valid input pending.
    tick();
    checks++;
    if ({out_valid, out_carry, out_data} !== 18'h0) begin
      errors++;
      $display("FAIL reset_held got v=%b c=%b d=%h want v=0 c=0 d=0000",
               out_valid, out_carry, out_data);
    end
    #3 rst_n = 1'b1;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_zero();
    in_valid = 1'b1;
    in_data  = 16'h0000;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0001 || out_carry !== 1'b0) begin
      errors++;
      $display("FAIL zero got v=%b c=%b d=%h want v=1 c=0 d=0001",
               out_valid, out_carry, out_data);
    end
  endtask

  task automatic test_wrap();
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0000 || out_carry !== 1'b1) begin
      errors++;
      $display("FAIL wrap got v=%b c=%b d=%h want v=1 c=1 d=0000",
               out_valid, out_carry, out_data);
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1;
    in_data  = 16'h0005;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0006 || out_carry !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got v=%b c=%b d=%h want v=1 c=0 d=0006",
               out_valid, out_carry, out_data);
    end
    in_data = 16'hFFFB;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hFFFC || out_carry !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second got v=%b c=%b d=%h want v=1 c=0 d=fffc",
               out_valid, out_carry, out_data);
    end
  endtask

  task automatic test_hold();
    in_valid = 1'b0;
    in_data  = 'x;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 16'hFFFC || out_carry !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d] got v=%b c=%b d=%h want v=0 c=0 d=fffc",
                 i, out_valid, out_carry, out_data);
      end
    end
    in_data = '0;
  endtask

`ifdef INC16_BYPASS_EN
  task automatic test_bypass();
    in_valid = 1'b1;
    bypass   = 1'b1;
    in_data  = 16'h1234;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_carry !== 1'b0) begin
      errors++;
      $display("FAIL bypass got v=%b c=%b d=%h want v=1 c=0 d=1234",
               out_valid, out_carry, out_data);
    end
    // A bypassed all-ones input must not raise the carry.
    in_data = 16'hFFFF;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hFFFF || out_carry !== 1'b0) begin
      errors++;
      $display("FAIL bypass_ffff got v=%b c=%b d=%h want v=1 c=0 d=ffff",
               out_valid, out_carry, out_data);
    end
    bypass = 1'b0;
  endtask
`endif

  // Random sweep with random valid gaps. The expected registered state is
  // tracked by the model.
  task automatic test_random(input int n);
    logic [15:0] exp_data;
    logic        exp_carry;
    logic        bp;
    logic [16:0] m;
    int          bad;
    bad       = 0;
    exp_data  = out_data;
    exp_carry = out_carry;
    for (int i = 0; i < n; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
      bp       = 1'b0;
`ifdef INC16_BYPASS_EN
      bp       = ($urandom_range(0, 3) == 0);
      bypass   = bp;
`endif
      if (in_valid) begin
        m         = model(in_data, bp);
        exp_data  = m[15:0];
        exp_carry = m[16];
      end
      tick();
      checks++;
      if (out_valid !== in_valid || out_data !== exp_data || out_carry !== exp_carry) begin
        errors++;
        if (bad < 10)
          $display("FAIL random[%0d] in=%h got v=%b c=%b d=%h want v=%b c=%b d=%h",
                   i, in_data, out_valid, out_carry, out_data,
                   in_valid, exp_carry, exp_data);
        bad++;
      end
    end
    in_valid = 1'b0;
`ifdef INC16_BYPASS_EN
    bypass = 1'b0;
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_zero();
    test_wrap();
    test_back_to_back();
    test_hold();
`ifdef INC16_BYPASS_EN
    test_bypass();
`endif
    test_random(10000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_inc16_pipe

// File: doc/inc16_pipe.md
Name: inc16_pipe

Overview:
- 16-bit incrementer: out = in + 1, modulo 2^16.
- Structural datapath: a carry chain of 16 half-adders with carry-in fixed at 1.
- Result is registered, with a single valid qualifier, so the block drops into clocked arithmetic pipelines (e.g. program-counter increment paths in the ALU/CPU datapath).

Parameters:
- none. Width is fixed at 16 by the shared package constant INC16_W.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous reset, active-low
- in_valid  input  1  in_data is valid this cycle
- in_data  input  16  operand
- out_valid  output  1  out_data holds a new result
- out_data  output  16  registered in_data + 1, modulo 2^16
- out_carry  output  1  carry out of bit 15; high only when in_data was 16'hFFFF

Behaviour:
- Reset (rst_n low, asynchronous, independent of clk):
  - out_data = 16'h0000, out_carry = 0, out_valid = 0.
  - Held while rst_n is low.
  - First capture happens on the first rising clk edge after rst_n deasserts.
- Combinational core:
  - sum[i] = in_data[i] XOR c[i]; c[i+1] = in_data[i] AND c[i]; c[0] = 1.
  - out_carry = c[16].
  - No behavioural "+" is required; a behavioural equivalent is acceptable if bit-exact.
- Capture: on each rising clk edge with in_valid = 1:
  - out_data <= sum, out_carry <= c[16], out_valid <= 1.
  - Latency is exactly one cycle.
- Hold: on a rising clk edge with in_valid = 0:
  - out_valid <= 0.
  - out_data and out_carry hold their last values.
- Throughput: one result per cycle. Back-to-back valid inputs produce back-to-back valid outputs with no bubbles.
- No backpressure: there is no ready signal, and the consumer must accept out_data whenever out_valid = 1.
- Wrap-around: 16'hFFFF -> out_data 16'h0000 with out_carry = 1. Every other input gives out_carry = 0.
- Reset mid-stream: an asserted rst_n discards any pending capture. Outputs go to their reset values immediately, without waiting for a clock edge.
- X on in_data while in_valid = 0 must not propagate to the outputs.

Optional Feature:
- Macro INC16_BYPASS_EN.
- When defined:
  - Adds input bypass (1 bit).
  - When bypass = 1 at a capture edge, out_data <= in_data unchanged and out_carry <= 0. This supports hold-PC style use.
  - Valid timing is unchanged.
- When undefined:
  - The port does not exist and the block always increments.

Decomposition:
- Package inc16_pkg:
  - localparam INC16_W = 16.
  - typedef logic [INC16_W-1:0] word_t, used for in_data and out_data.
- Sub-module inc16_half_adder (ports a, b -> sum, carry), instantiated 16 times in a generate loop to form the carry chain.
- Top-level inc16_pipe contains the chain, the optional bypass mux and the output registers.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle with outputs non-zero -> out_data = 0000, out_carry = 0, out_valid = 0 immediately, without a clock edge.
- Zero: in_data = 16'h0000, in_valid = 1 -> next cycle out_data = 16'h0001, out_carry = 0, out_valid = 1.
- Wrap: in_data = 16'hFFFF -> next cycle out_data = 16'h0000, out_carry = 1.
- Mid values, back-to-back on consecutive cycles:
  - 16'h0005 -> 16'h0006.
  - 16'hFFFB -> 16'hFFFC (carry 0).
  - out_valid stays high for both cycles.
- Hold: in_valid = 0 for 3 cycles after the previous case -> out_valid = 0; out_data stays 16'hFFFC; in_data driven to X has no effect.
- Bypass (INC16_BYPASS_EN defined): bypass = 1, in_data = 16'h1234 -> out_data = 16'h1234, out_carry = 0. Random sweep of 10k values with bypass = 0 matches (in_data + 1) & 16'hFFFF.
